// File: rtl/sparc_tlu_pkg.sv
// Shared TLU constants for the per-thread CCR trap stack.
// Also holds the level-range helper used by the read and write paths.
package sparc_tlu_pkg;

  localparam int MAXTL = 6;
  localparam int TLW   = 3;
  localparam int CCR_W = 8;
  localparam int NTHR  = 4;

  localparam logic [TLW-1:0] MAXTL_V = TLW'(MAXTL);
  localparam logic [TLW-1:0] TL_ZERO = {TLW{1'b0}};
  localparam logic [TLW-1:0] TL_ONE  = {{(TLW-1){1'b0}}, 1'b1};

  // Stack levels are 1-based; level 0 and anything above MAXTL are not storage.
  function automatic logic tl_in_range(input logic [TLW-1:0] tl);
    return (tl != TL_ZERO) && (tl <= MAXTL_V);
  endfunction

endpackage

// File: rtl/sparc_tlu_ccrstk_thr.sv
// One thread's CCR trap stack: TL counter plus MAXTL saved CCR entries.
// Push takes priority over a WRPR to the same level; pop never coincides with push.
module sparc_tlu_ccrstk_thr
  import sparc_tlu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [CCR_W-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             wr_i,
  input  logic [TLW-1:0]   wr_tl_i,
  input  logic [CCR_W-1:0] wr_data_i,
  input  logic [TLW-1:0]   rd_tl_i,
  output logic [TLW-1:0]   tl_o,
  output logic [CCR_W-1:0] rd_data_o,
  output logic [CCR_W-1:0] top_data_o
);

  logic [TLW-1:0]   tl_q, tl_d;
  logic [TLW-1:0]   push_lvl_s;
  logic [CCR_W-1:0] entry_q [MAXTL];
  logic [CCR_W-1:0] entry_d [MAXTL];

  // Next TL and entry contents from push, pop and WRPR.
  always_comb begin
    push_lvl_s = (tl_q == MAXTL_V) ? MAXTL_V : (tl_q + TL_ONE);
    for (int i = 0; i < MAXTL; i++) begin
      if (push_i && (push_lvl_s == TLW'(i + 1))) begin
        entry_d[i] = push_data_i;
      end else if (wr_i && (wr_tl_i == TLW'(i + 1))) begin
        entry_d[i] = wr_data_i;
      end else begin
        entry_d[i] = entry_q[i];
      end
    end
    if (push_i) begin
      tl_d = push_lvl_s;
    end else if (pop_i && (tl_q != TL_ZERO)) begin
      tl_d = tl_q - TL_ONE;
    end else begin
      tl_d = tl_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tl_q <= TL_ZERO;
      for (int i = 0; i < MAXTL; i++) begin
        entry_q[i] <= {CCR_W{1'b0}};
      end
    end else begin
      tl_q    <= tl_d;
      entry_q <= entry_d;
    end
  end

  // Read ports: arbitrary level for RDPR, current top-of-stack for restore.
  always_comb begin
    rd_data_o  = tl_in_range(rd_tl_i) ? entry_q[rd_tl_i - TL_ONE] : {CCR_W{1'b0}};
    top_data_o = (tl_q != TL_ZERO) ? entry_q[tl_q - TL_ONE] : {CCR_W{1'b0}};
  end

  assign tl_o = tl_q;

endmodule

// File: rtl/sparc_tlu_ccrstk.sv
// TLU trap-level stack for TSTATE.CCR: push on W-stage trap, pop on DONE/RETRY
// via an E->M pipeline, plus RDPR/WRPR access to any saved level.
module sparc_tlu_ccrstk
  import sparc_tlu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CCR_W-1:0] exu_tlu_ccr0_w,
  input  logic [CCR_W-1:0] exu_tlu_ccr1_w,
  input  logic [CCR_W-1:0] exu_tlu_ccr2_w,
  input  logic [CCR_W-1:0] exu_tlu_ccr3_w,
  input  logic             trap_vld_w,
  input  logic [1:0]       trap_tid_w,
  input  logic             dnrtry_vld_e,
  input  logic [1:0]       dnrtry_tid_e,
  input  logic             ifu_exu_kill_e,
  input  logic             wrpr_vld,
  input  logic [1:0]       wrpr_tid,
  input  logic [TLW-1:0]   wrpr_tl,
  input  logic [CCR_W-1:0] wrpr_data,
  input  logic [1:0]       rdpr_tid,
  input  logic [TLW-1:0]   rdpr_tl,
  output logic [CCR_W-1:0] rdpr_data,
  output logic             tlu_exu_cwpccr_update_m,
  output logic [CCR_W-1:0] tlu_exu_ccr_m,
  output logic [TLW-1:0]   tl_thr0,
  output logic [TLW-1:0]   tl_thr1,
  output logic [TLW-1:0]   tl_thr2,
  output logic [TLW-1:0]   tl_thr3,
  output logic             tl_ovf,
  output logic             tl_unf
);

  logic             pop_m_q, pop_m_d;
  logic [1:0]       tid_m_q, tid_m_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [NTHR-1:0]  push_en_s, pop_en_s, wr_en_s;
  logic [CCR_W-1:0] push_ccr_s;
  logic             squash_s, strobe_s;
  logic [TLW-1:0]   tl_s   [NTHR];
  logic [CCR_W-1:0] rd_s   [NTHR];
  logic [CCR_W-1:0] top_s  [NTHR];

  // Thread decode, same-thread squash (older W trap wins) and pulse sources.
  always_comb begin
    push_en_s = {NTHR{1'b0}};
    pop_en_s  = {NTHR{1'b0}};
    wr_en_s   = {NTHR{1'b0}};
    case (trap_tid_w)
      2'd0:    push_ccr_s = exu_tlu_ccr0_w;
      2'd1:    push_ccr_s = exu_tlu_ccr1_w;
      2'd2:    push_ccr_s = exu_tlu_ccr2_w;
      2'd3:    push_ccr_s = exu_tlu_ccr3_w;
      default: push_ccr_s = exu_tlu_ccr0_w;
    endcase
    if (trap_vld_w) begin
      push_en_s[trap_tid_w] = 1'b1;
    end else begin
      push_en_s = {NTHR{1'b0}};
    end
    if (wrpr_vld) begin
      wr_en_s[wrpr_tid] = 1'b1;
    end else begin
      wr_en_s = {NTHR{1'b0}};
    end
    squash_s = trap_vld_w && (trap_tid_w == tid_m_q);
    strobe_s = pop_m_q && (tl_s[tid_m_q] != TL_ZERO) && !squash_s;
    if (strobe_s) begin
      pop_en_s[tid_m_q] = 1'b1;
    end else begin
      pop_en_s = {NTHR{1'b0}};
    end
    ovf_d   = trap_vld_w && (tl_s[trap_tid_w] == MAXTL_V);
    unf_d   = pop_m_q && (tl_s[tid_m_q] == TL_ZERO) && !squash_s;
    pop_m_d = dnrtry_vld_e && !ifu_exu_kill_e;
    tid_m_d = dnrtry_tid_e;
  end

  // E->M pop flop and overflow/underflow pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_m_q <= 1'b0;
      tid_m_q <= 2'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pop_m_q <= pop_m_d;
      tid_m_q <= tid_m_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  for (genvar g = 0; g < NTHR; g++) begin : g_thr
    sparc_tlu_ccrstk_thr u_thr (
      .clk_i       (clk),
      .rst_i       (rst),
      .push_i      (push_en_s[g]),
      .push_data_i (push_ccr_s),
      .pop_i       (pop_en_s[g]),
      .wr_i        (wr_en_s[g]),
      .wr_tl_i     (wrpr_tl),
      .wr_data_i   (wrpr_data),
      .rd_tl_i     (rdpr_tl),
      .tl_o        (tl_s[g]),
      .rd_data_o   (rd_s[g]),
      .top_data_o  (top_s[g])
    );
  end

  // The strobe must see this cycle's W trap to squash, so it is decoded from M-stage flops.
  always_comb begin
    tlu_exu_cwpccr_update_m = strobe_s;
    tlu_exu_ccr_m           = strobe_s ? top_s[tid_m_q] : {CCR_W{1'b0}};
    rdpr_data               = rd_s[rdpr_tid];
  end

  assign tl_thr0 = tl_s[0];
  assign tl_thr1 = tl_s[1];
  assign tl_thr2 = tl_s[2];
  assign tl_thr3 = tl_s[3];
  assign tl_ovf  = ovf_q;
  assign tl_unf  = unf_q;

endmodule
